// File: rtl/risc_pkg.sv
// Shared widths and the load-buffer entry type for the register-file write-back path.
package risc_pkg;

    localparam int unsigned REG_AW   = 3;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } ld_entry_t;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_AW-1:0] d);
        logic [NUM_REGS-1:0] oh;
        oh    = '0;
        oh[d] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// Load-result FIFO whose entries can be squashed in place by destination match.
module wb_ld_fifo
    import risc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push_en,
    input  ld_entry_t           push_entry,
    input  logic                pop_en,
    input  logic                kill_en,
    input  logic [REG_AW-1:0]   kill_dest,
    output logic                full,
    output logic                empty,
    output ld_entry_t           head,
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    ld_entry_t        mem_q [DEPTH];
    ld_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[head_q];

    // Popped slots are cleared to dead so that 'live' alone marks valid occupancy.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (kill_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[i].dest == kill_dest) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end
        if (pop_en) begin
            mem_d[head_q].live = 1'b0;
            head_d             = head_q + 1'b1;
        end
        if (push_en) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + 1'b1;
        end
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_q[i].live) begin
                busy_mask = busy_mask | dest_onehot(mem_q[i].dest);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load results onto one register-file write port, ALU first.
// Define WB_ARBITER_BYPASS_EN to let a load skip an empty FIFO when the ALU is idle.
module wb_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                alu_valid,
    input  logic [REG_AW-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [REG_AW-1:0]   ld_dest,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                reg_write_en,
    output logic [REG_AW-1:0]   reg_write_dest,
    output logic [DATA_W-1:0]   reg_write_data,
    output logic [NUM_REGS-1:0] busy_mask
);

    logic              fifo_full;
    logic              fifo_empty;
    ld_entry_t         fifo_head;
    ld_entry_t         push_entry;
    logic              ld_accept;
    logic              bypass_take;
    logic              push_en;
    logic              pop_en;

    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    assign ld_ready  = reset_n && !fifo_full;
    assign ld_accept = ld_valid && ld_ready;
    assign pop_en    = !alu_valid && !fifo_empty;

`ifdef WB_ARBITER_BYPASS_EN
    assign bypass_take = ld_accept && !alu_valid && fifo_empty;
`else
    assign bypass_take = 1'b0;
`endif

    assign push_en = ld_accept && !bypass_take;

    // A load colliding with a same-cycle ALU write is older, so it lands already dead.
    always_comb begin
        push_entry      = '0;
        push_entry.live = !(alu_valid && (ld_dest == alu_dest));
        push_entry.dest = ld_dest;
        push_entry.data = ld_data;
    end

    wb_ld_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_en    (push_en),
        .push_entry (push_entry),
        .pop_en     (pop_en),
        .kill_en    (alu_valid),
        .kill_dest  (alu_dest),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .busy_mask  (busy_mask)
    );

    always_comb begin
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        if (alu_valid) begin
            wr_en_d   = 1'b1;
            wr_dest_d = alu_dest;
            wr_data_d = alu_data;
        end else if (pop_en) begin
            if (fifo_head.live) begin
                wr_en_d   = 1'b1;
                wr_dest_d = fifo_head.dest;
                wr_data_d = fifo_head.data;
            end
        end else if (bypass_take) begin
            wr_en_d   = 1'b1;
            wr_dest_d = ld_dest;
            wr_data_d = ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter; each driven cycle queues the write expected one edge later.
module tb_wb_arbiter;
    import risc_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef WB_ARBITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                reset_n;
    logic                alu_valid;
    logic [REG_AW-1:0]   alu_dest;
    logic [DATA_W-1:0]   alu_data;
    logic                ld_valid;
    logic                ld_ready;
    logic [REG_AW-1:0]   ld_dest;
    logic [DATA_W-1:0]   ld_data;
    logic                reg_write_en;
    logic [REG_AW-1:0]   reg_write_dest;
    logic [DATA_W-1:0]   reg_write_data;
    logic [NUM_REGS-1:0] busy_mask;

    wb_arbiter #(
        .LD_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_valid      (alu_valid),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_dest        (ld_dest),
        .ld_data        (ld_data),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .busy_mask      (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t         exp_q [$];
    ld_entry_t   mq    [$];
    int unsigned n_tests;
    int unsigned n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] model_busy();
        logic [NUM_REGS-1:0] m;
        m = '0;
        foreach (mq[i]) begin
            if (mq[i].live) m[mq[i].dest] = 1'b1;
        end
        return m;
    endfunction

    task automatic step(input logic av, input logic [REG_AW-1:0] ad, input logic [DATA_W-1:0] ax,
                        input logic lv, input logic [REG_AW-1:0] ldd, input logic [DATA_W-1:0] lx);
        wr_t       w;
        ld_entry_t e;
        logic      acc;
        logic      taken;
        alu_valid = av;
        alu_dest  = ad;
        alu_data  = ax;
        ld_valid  = lv;
        ld_dest   = ldd;
        ld_data   = lx;
        check_eq("ld_ready", 32'(ld_ready), 32'(mq.size() < DEPTH));
        check_eq("busy_mask", 32'(busy_mask), 32'(model_busy()));
        acc   = lv && (mq.size() < DEPTH);
        taken = 1'b0;
        w.en   = 1'b0;
        w.dest = '0;
        w.data = '0;
        if (av) begin
            foreach (mq[i]) begin
                if (mq[i].dest == ad) begin
                    e      = mq[i];
                    e.live = 1'b0;
                    mq[i]  = e;
                end
            end
            w.en = 1'b1; w.dest = ad; w.data = ax;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live) begin
                w.en = 1'b1; w.dest = e.dest; w.data = e.data;
            end
        end else if (BYP && acc) begin
            w.en = 1'b1; w.dest = ldd; w.data = lx;
            taken = 1'b1;
        end
        if (acc && !taken) begin
            e.live = !(av && (ad == ldd));
            e.dest = ldd;
            e.data = lx;
            mq.push_back(e);
        end
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        w = exp_q.pop_front();
        check_eq("wr_en", 32'(reg_write_en), 32'(w.en));
        if (w.en) begin
            check_eq("wr_dest", 32'(reg_write_dest), 32'(w.dest));
            check_eq("wr_data", 32'(reg_write_data), 32'(w.data));
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"},    32'(reg_write_en),   32'h0);
        check_eq({tag, "_dest"},  32'(reg_write_dest), 32'h0);
        check_eq({tag, "_data"},  32'(reg_write_data), 32'h0);
        check_eq({tag, "_busy"},  32'(busy_mask),      32'h0);
        check_eq({tag, "_ready"}, 32'(ld_ready),       32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        alu_valid = 1'b0;
        alu_dest  = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_dest   = '0;
        ld_data   = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_reset", 32'(ld_ready), 32'h1);

        // ALU write, latency 1
        step(1'b1, 3'd3, 16'h1234, 1'b0, '0, '0);
        check_eq("alu_r3", {reg_write_en, 12'h0, reg_write_dest, reg_write_data}, {1'b1, 12'h0, 3'd3, 16'h1234});

        // Load latency: 2 without bypass, 1 with bypass
        step(1'b0, '0, '0, 1'b1, 3'd5, 16'hBEEF);
        check_eq("ld_lat1_en", 32'(reg_write_en), 32'(BYP));
        idle(1);
        check_eq("ld_lat2_en", 32'(reg_write_en), 32'(!BYP));
        idle(1);

        // ALU held busy while two loads fill the buffer
        step(1'b1, 3'd7, 16'hA000, 1'b1, 3'd1, 16'h1111);
        step(1'b1, 3'd7, 16'hA001, 1'b1, 3'd2, 16'h2222);
        check_eq("full_ready", 32'(ld_ready), 32'h0);
        check_eq("full_busy", 32'(busy_mask), 32'h06);
        step(1'b1, 3'd0, 16'hA002, 1'b1, 3'd3, 16'h3333);
        step(1'b1, 3'd0, 16'hA003, 1'b1, 3'd3, 16'h3333);
        idle(3);

        // WAW squash of a buffered load
        step(1'b1, 3'd0, 16'h0011, 1'b1, 3'd4, 16'h4444);
        check_eq("squash_busy_before", 32'(busy_mask), 32'h10);
        step(1'b1, 3'd4, 16'h0001, 1'b0, '0, '0);
        check_eq("squash_busy_after", 32'(busy_mask), 32'h00);
        idle(1);
        check_eq("dead_pop_en", 32'(reg_write_en), 32'h0);
        idle(1);

        // Same-cycle ALU and load to the same register
        step(1'b1, 3'd6, 16'h6666, 1'b1, 3'd6, 16'hDEAD);
        check_eq("same_cycle_busy", 32'(busy_mask), 32'h00);
        idle(3);

        // Reset in the middle of a full buffer
        step(1'b1, 3'd0, 16'h00A0, 1'b1, 3'd1, 16'h000A);
        step(1'b1, 3'd0, 16'h00A1, 1'b1, 3'd2, 16'h000B);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mq.delete();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_midreset", 32'(ld_ready), 32'h1);
        idle(3);

        for (int unsigned i = 0; i < 300; i++) begin
            step($urandom_range(0, 2) == 0, REG_AW'($urandom_range(0, 7)), DATA_W'($urandom),
                 $urandom_range(0, 1) == 1, REG_AW'($urandom_range(0, 7)), DATA_W'($urandom));
        end
        idle(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: LD_DEPTH, 2, load-result buffer depth in entries (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state rises on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 alu_valid  input  1  ALU result present this cycle (no backpressure; always accepted).
REQ-005 alu_dest  input  3  ALU destination register.
REQ-006 alu_data  input  16  ALU result.
REQ-007 ld_valid  input  1  load result offered.
REQ-008 ld_ready  output  1  load result can be accepted.
REQ-009 ld_dest  input  3  load destination register.
REQ-010 ld_data  input  16  load data.
REQ-011 reg_write_en  output  1  register-file write enable.
REQ-012 reg_write_dest  output  3  register-file write address.
REQ-013 reg_write_data  output  16  register-file write data.
REQ-014 busy_mask  output  8  bit d set while a live buffered load targets register d.

Function
REQ-015 The block SHALL merge ALU and load results onto the single register-file write port; reg_write_* are registered outputs.
REQ-016 A load SHALL be accepted on a cycle with ld_valid && ld_ready; ld_ready SHALL equal (count < LD_DEPTH), combinational from state only.
REQ-017 Accepted loads SHALL enter a FIFO of LD_DEPTH entries {live, dest, data}; pointers wrap modulo LD_DEPTH.
REQ-018 Priority: alu_valid SHALL win; the next cycle drives reg_write_en=1 with alu_dest/alu_data (latency 1).
REQ-019 When alu_valid=0 and the FIFO is non-empty, the head SHALL pop; a live head drives a write next cycle, a dead head pops with reg_write_en=0.
REQ-020 With no ALU result and no pop, reg_write_en SHALL be 0 next cycle; dest/data hold their previous values.
REQ-021 WAW squash: on alu_valid, every FIFO entry with dest==alu_dest SHALL be marked dead in the same cycle.
REQ-022 A load accepted in the same cycle as alu_valid with equal dest SHALL be stored dead (the load is treated as older).
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; full FIFO with simultaneous pop still reports ld_ready=0 that cycle.
REQ-024 busy_mask SHALL be the OR of one-hot(dest) over live entries, combinational from current FIFO state.
REQ-025 Without bypass (REQ-030), load-to-write latency SHALL be 2 cycles minimum.

Reset
REQ-026 While reset_n=0: FIFO empty, all entries dead, reg_write_en=0, reg_write_dest=0, reg_write_data=0, busy_mask=0, ld_ready=0.
REQ-027 ld_ready SHALL be 1 from the first cycle after reset_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all buffered loads; no write is issued for them.

Configuration
REQ-029 Macro WB_ARBITER_BYPASS_EN selects load bypass.
REQ-030 Defined: a load accepted with alu_valid=0 and the FIFO empty SHALL go directly to the output register (latency 1) and SHALL NOT enter the FIFO. Undefined: every load passes through the FIFO (REQ-025).

Structure
REQ-031 Package risc_pkg SHALL hold the register-address width (3), data width (16) and the FIFO entry struct typedef.
REQ-032 The FIFO SHALL be a sub-module wb_ld_fifo with per-entry dest-compare kill inputs; wb_arbiter holds only arbitration and the output register.

Verification
REQ-033 Reset then alu_valid, dest=3, data=0x1234 -> next cycle reg_write_en=1, dest=3, data=0x1234.
REQ-034 No bypass: load dest=5, data=0xBEEF with ALU idle -> write dest=5 two cycles after acceptance; with bypass, one cycle after.
REQ-035 alu_valid held high for 4 cycles while loads dest=1 then dest=2 are offered -> ld_ready=0 after 2 accepts, busy_mask=0x06; after ALU stops, writes r1 then r2.
REQ-036 Load dest=4 buffered, then alu_valid dest=4, data=0x0001 -> busy_mask bit 4 clears; only the ALU write to r4 occurs; dead pop has reg_write_en=0.
REQ-037 Same-cycle ALU and load, both dest=6 -> only the ALU value is written to r6.
REQ-038 FIFO full with 2 loads, reset_n pulsed low -> outputs 0 immediately, no subsequent write, ld_ready=1 after release.
